// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package riscv_fetch_pkg;

   localparam int FETCH_ADDR_WIDTH  = 64;
   localparam int FETCH_INSTR_WIDTH = 32;
   localparam int INSTR_BYTES       = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_INSTR_WIDTH-1:0] instr;
      logic [FETCH_ADDR_WIDTH-1:0]  pc;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_ctrl_if.sv
// Memory read port and decode handshake of the fetch sequencer.
// master = fetch side, slave = memory/decode side.
interface riscv_fetch_ctrl_if #(
   parameter int ADDR_WIDTH  = 64,
   parameter int INSTR_WIDTH = 32
);
   logic                   o_mem_read;
   logic [ADDR_WIDTH-1:0]  o_mem_pc;
   logic                   i_mem_valid;
   logic [INSTR_WIDTH-1:0] i_mem_instr;
   logic                   o_valid;
   logic                   i_ready;
   logic [INSTR_WIDTH-1:0] o_instr;
   logic [ADDR_WIDTH-1:0]  o_pc;

   modport master (
      output o_mem_read, o_mem_pc, o_valid, o_instr, o_pc,
      input  i_mem_valid, i_mem_instr, i_ready
   );

   modport slave (
      input  o_mem_read, o_mem_pc, o_valid, o_instr, o_pc,
      output i_mem_valid, i_mem_instr, i_ready
   );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Prefetch queue (synchronous FIFO of fetch entries) and its checker.
module riscv_fetch_queue_chk (
   input logic clk,
   input logic nreset,
   input logic push_req,
   input logic full
);
   // the fetch credit scheme must always leave room for a returning response
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!nreset)
      push_req |-> !full);
endmodule

module riscv_fetch_queue
   import riscv_fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter int  CNT_W   = $clog2(DEPTH) + 1,
   parameter type entry_t = fetch_entry_t
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             push,
   input  entry_t           push_data,
   input  logic             pop,
   input  logic             flush,
   output entry_t           head,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = $clog2(DEPTH);

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty = (count_r == {CNT_W{1'b0}});
   assign full  = (count_r == CNT_W'(DEPTH));
   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

   // qualify requests: no pop from empty, push into full only alongside a pop
   always_comb begin
      do_pop_s  = pop & ~empty;
      do_push_s = push & (~full | do_pop_s);
   end

   // pointer and occupancy bookkeeping; flush empties the queue at once
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
         else           wr_ptr_r <= wr_ptr_r;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
         else           rd_ptr_r <= rd_ptr_r;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

   // entry storage
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= entry_t'({$bits(entry_t){1'b0}});
      end else if (do_push_s && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end else begin
         mem_r <= mem_r;
      end
   end
endmodule

// File: rtl/riscv_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one read per cycle under
// a queue credit, buffers responses and hands them to decode.
// Optional: RISCV_FETCH_MISALIGN_CHK_EN adds o_misalign and the FAULT state.
module riscv_fetch_ctrl
   import riscv_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH  = 64,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    QUEUE_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 64'h0
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  enable,
   input  logic                  i_start,
   input  logic                  i_redirect,
   input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
   riscv_fetch_ctrl_if.master    bus,
`ifdef RISCV_FETCH_MISALIGN_CHK_EN
   output logic                  o_misalign,
`endif
   output logic                  o_busy
);
   localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [ADDR_WIDTH-1:0]  pc;
   } entry_t;

   fetch_state_e           state_r, state_nxt_s, redir_state_s;
   logic [ADDR_WIDTH-1:0]  pc_r, pc_nxt_s, inflight_pc_r;
   logic                   inflight_r;
   logic                   issue_s, flush_s, resp_s, push_s, pop_s, credit_s;
   logic [CNT_W:0]         used_s;
   logic [CNT_W-1:0]       count_s;
   logic                   empty_s, full_s;
   entry_t                 head_s, push_entry_s;
   logic [INSTR_WIDTH-1:0] last_instr_r;
   logic [ADDR_WIDTH-1:0]  last_pc_r;

`ifdef RISCV_FETCH_MISALIGN_CHK_EN
   assign redir_state_s = (i_redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
   assign o_misalign    = (state_r == FAULT);
`else
   assign redir_state_s = RUN;
`endif

   // a read may only go out if its response is guaranteed a queue slot
   assign used_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r};
   assign credit_s = (used_s < (CNT_W+1)'(QUEUE_DEPTH));

   // next state, next PC, issue and flush decisions
   always_comb begin
      state_nxt_s = state_r;
      pc_nxt_s    = pc_r;
      issue_s     = 1'b0;
      flush_s     = 1'b0;
      if (enable) begin
         case (state_r)
            IDLE: begin
               if (i_redirect) begin
                  flush_s     = 1'b1;
                  pc_nxt_s    = i_redirect_pc;
                  state_nxt_s = redir_state_s;
               end else if (i_start) begin
                  pc_nxt_s    = RESET_PC;
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            RUN: begin
               if (i_redirect) begin
                  flush_s     = 1'b1;
                  pc_nxt_s    = i_redirect_pc;
                  state_nxt_s = redir_state_s;
               end else if (credit_s) begin
                  issue_s     = 1'b1;
                  pc_nxt_s    = pc_r + ADDR_WIDTH'(INSTR_BYTES);
               end else begin
                  issue_s     = 1'b0;
               end
            end
`ifdef RISCV_FETCH_MISALIGN_CHK_EN
            FAULT: begin
               if (i_redirect) begin
                  flush_s     = 1'b1;
                  pc_nxt_s    = i_redirect_pc;
                  state_nxt_s = redir_state_s;
               end else begin
                  state_nxt_s = FAULT;
               end
            end
`endif
            default: state_nxt_s = IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // state, PC and in-flight tracking; everything freezes while disabled
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r       <= IDLE;
         pc_r          <= RESET_PC;
         inflight_r    <= 1'b0;
         inflight_pc_r <= {ADDR_WIDTH{1'b0}};
      end else if (enable) begin
         state_r    <= state_nxt_s;
         pc_r       <= pc_nxt_s;
         inflight_r <= issue_s;
         if (issue_s) inflight_pc_r <= pc_r;
         else         inflight_pc_r <= inflight_pc_r;
      end else begin
         state_r <= state_r;
      end
   end

   // a redirect discards the response arriving in the same cycle and wins over a pop
   assign resp_s       = enable & bus.i_mem_valid & inflight_r & ~i_redirect;
   assign push_s       = resp_s & (~full_s | pop_s);
   assign pop_s        = enable & bus.o_valid & bus.i_ready & ~i_redirect;
   assign push_entry_s = '{instr: bus.i_mem_instr, pc: inflight_pc_r};

   riscv_fetch_queue #(
      .DEPTH   (QUEUE_DEPTH),
      .CNT_W   (CNT_W),
      .entry_t (entry_t)
   ) u_queue (
      .clk       (clk),
      .nreset    (nreset),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .flush     (flush_s),
      .head      (head_s),
      .count     (count_s),
      .empty     (empty_s),
      .full      (full_s)
   );

   riscv_fetch_queue_chk u_chk (
      .clk      (clk),
      .nreset   (nreset),
      .push_req (resp_s),
      .full     (full_s)
   );

   // remember the most recent head so the outputs hold once the queue drains
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         last_instr_r <= {INSTR_WIDTH{1'b0}};
         last_pc_r    <= {ADDR_WIDTH{1'b0}};
      end else if (!empty_s) begin
         last_instr_r <= head_s.instr;
         last_pc_r    <= head_s.pc;
      end else begin
         last_instr_r <= last_instr_r;
         last_pc_r    <= last_pc_r;
      end
   end

   assign bus.o_mem_read = issue_s;
   assign bus.o_mem_pc   = pc_r;
   assign bus.o_valid    = ~empty_s;
   assign bus.o_instr    = empty_s ? last_instr_r : head_s.instr;
   assign bus.o_pc       = empty_s ? last_pc_r    : head_s.pc;
   assign o_busy         = (state_r != IDLE);
endmodule
